// File: rtl/fpu_stack_pkg.sv
// Shared encodings and helpers for the 8087 register-stack controller.
// Covers command opcodes, tag values, FSM states and the indefinite QNaN.
package fpu_stack_pkg;

   localparam int unsigned REG_W     = 80;
   localparam int unsigned NUM_REGS  = 8;
   localparam int unsigned IDX_W     = 3;
   localparam int unsigned TAG_W     = 2;
   localparam int unsigned OP_W      = 4;
   localparam int unsigned TAGWORD_W = NUM_REGS * TAG_W;

   localparam logic [REG_W-1:0] FPU_INDEF = 80'hFFFF_C000_0000_0000_0000;

   typedef enum logic [OP_W-1:0] {
      OP_NOP       = 4'd0,
      OP_INIT      = 4'd1,
      OP_PUSH      = 4'd2,
      OP_POP       = 4'd3,
      OP_READ      = 4'd4,
      OP_WRITE     = 4'd5,
      OP_XCH       = 4'd6,
      OP_FREE      = 4'd7,
      OP_INCSTP    = 4'd8,
      OP_DECSTP    = 4'd9,
      OP_WRITE_POP = 4'd10
   } op_e;

   typedef enum logic [TAG_W-1:0] {
      TAG_VALID   = 2'b00,
      TAG_ZERO    = 2'b01,
      TAG_SPECIAL = 2'b10,
      TAG_EMPTY   = 2'b11
   } tag_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXEC    = 2'd1,
      ST_XCH_WR2 = 2'd2
   } state_e;

   // Latched command header; the wide data word is held separately.
   typedef struct packed {
      op_e              op;
      logic [IDX_W-1:0] idx;
      tag_e             tag;
   } cmd_hdr_t;

   // Undefined opcodes behave as NOP.
   function automatic op_e decode_op(input logic [OP_W-1:0] raw);
      return (raw > OP_W'(OP_WRITE_POP)) ? OP_NOP : op_e'(raw);
   endfunction

   function automatic tag_e tag_of(input logic [TAGWORD_W-1:0] tw,
                                   input logic [IDX_W-1:0]     k);
      return tag_e'(tw[{k, 1'b0} +: TAG_W]);
   endfunction

   function automatic logic [TAGWORD_W-1:0] tag_set(input logic [TAGWORD_W-1:0] tw,
                                                    input logic [IDX_W-1:0]     k,
                                                    input tag_e                 t);
      logic [TAGWORD_W-1:0] r;
      r = tw;
      r[{k, 1'b0} +: TAG_W] = t;
      return r;
   endfunction

endpackage

// File: rtl/fpu_stack_ctrl_if.sv
// Command/response bundle between the FPU microsequencer and the stack controller.
// master = microsequencer side, slave = stack controller.
interface fpu_stack_ctrl_if
   import fpu_stack_pkg::*;
#(
   parameter int unsigned WIDTH = REG_W
) ();

   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [OP_W-1:0]      cmd_op;
   logic [IDX_W-1:0]     cmd_idx;
   logic [WIDTH-1:0]     cmd_data;
   logic [TAG_W-1:0]     cmd_tag;
   logic [WIDTH-1:0]     rd_data;
   logic                 done;
   logic [IDX_W-1:0]     top;
   logic [TAGWORD_W-1:0] tag_word;
   logic                 exc_invalid;
   logic                 exc_sf;
   logic                 c1;

   modport master (
      output cmd_valid, cmd_op, cmd_idx, cmd_data, cmd_tag,
      input  cmd_ready, rd_data, done, top, tag_word, exc_invalid, exc_sf, c1
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_idx, cmd_data, cmd_tag,
      output cmd_ready, rd_data, done, top, tag_word, exc_invalid, exc_sf, c1
   );

endinterface

// File: rtl/fpu_stack_regfile.sv
// Eight-entry physical register file: two combinational read ports, one write port.
// Contents are deliberately not reset.
module fpu_stack_regfile
   import fpu_stack_pkg::*;
#(
   parameter int unsigned WIDTH = REG_W
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [IDX_W-1:0] raddr_a,
   output logic [WIDTH-1:0] rdata_a_c,
   input  logic [IDX_W-1:0] raddr_b,
   output logic [WIDTH-1:0] rdata_b_c
);

   logic [WIDTH-1:0] mem [NUM_REGS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_a_c = mem[raddr_a];
   assign rdata_b_c = mem[raddr_b];

endmodule

// File: rtl/fpu_stack_ctrl.sv
// 8087 register-stack sequencer: owns TOP and the tag word, maps ST(i) to physical
// registers and applies the masked invalid-operation response on stack faults.
module fpu_stack_ctrl
   import fpu_stack_pkg::*;
#(
   parameter int unsigned     WIDTH = REG_W,
   parameter logic [WIDTH-1:0] INDEF = WIDTH'(FPU_INDEF)
) (
   input  logic             clk,
   input  logic             reset_n,
   fpu_stack_ctrl_if.slave  bus
);

   state_e           state;
   cmd_hdr_t         cmd_q;
   logic [IDX_W-1:0] phys_q;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] s0_q;
   logic [WIDTH-1:0] si_q;
   tag_e             s0_tag_q;
   tag_e             si_tag_q;
   logic             fault_q;

   op_e                  op_c;
   logic [IDX_W-1:0]     phys_i_c;
   logic [IDX_W-1:0]     push_c;
   logic [WIDTH-1:0]     rd_i_c;
   logic [WIDTH-1:0]     rd_s0_c;
   logic                 empty_i_c;
   logic                 empty_s0_c;
   logic                 empty_push_c;
   logic                 fault_c;
   logic                 over_c;
   logic                 we_c;
   logic [IDX_W-1:0]     waddr_c;
   logic [WIDTH-1:0]     wdata_c;
   logic [IDX_W-1:0]     top_nxt_c;
   logic [TAGWORD_W-1:0] tag_nxt_c;

   assign op_c         = decode_op(bus.cmd_op);
   assign phys_i_c     = bus.top + bus.cmd_idx;
   assign push_c       = bus.top - IDX_W'(1);
   assign empty_i_c    = (tag_of(bus.tag_word, phys_i_c) == TAG_EMPTY);
   assign empty_s0_c   = (tag_of(bus.tag_word, bus.top) == TAG_EMPTY);
   assign empty_push_c = (tag_of(bus.tag_word, push_c) == TAG_EMPTY);

   fpu_stack_regfile #(.WIDTH(WIDTH)) u_regfile (
      .clk       (clk),
      .we        (we_c & reset_n),
      .waddr     (waddr_c),
      .wdata     (wdata_c),
      .raddr_a   (phys_i_c),
      .rdata_a_c (rd_i_c),
      .raddr_b   (bus.top),
      .rdata_b_c (rd_s0_c)
   );

   // Fault is decided at accept time so the exception can pulse together with done.
   always_comb begin
      fault_c = 1'b0;
      over_c  = 1'b0;
      case (op_c)
         OP_PUSH: begin
            fault_c = !empty_push_c;
            over_c  = 1'b1;
         end
         OP_POP, OP_WRITE_POP: fault_c = empty_s0_c;
         OP_READ:              fault_c = empty_i_c;
         OP_XCH:               fault_c = (bus.cmd_idx != '0) && (empty_i_c || empty_s0_c);
         default: ;
      endcase
   end

   // Single write port: XCH spreads its two writes over EXEC and XCH_WR2.
   always_comb begin
      we_c    = 1'b0;
      waddr_c = phys_q;
      wdata_c = data_q;
      case (state)
         ST_EXEC: begin
            case (cmd_q.op)
               OP_PUSH: begin
                  we_c    = 1'b1;
                  wdata_c = fault_q ? INDEF : data_q;
               end
               OP_WRITE, OP_WRITE_POP: we_c = 1'b1;
               OP_XCH: begin
                  we_c    = (cmd_q.idx != '0);
                  waddr_c = bus.top;
                  wdata_c = si_q;
               end
               default: ;
            endcase
         end
         ST_XCH_WR2: begin
            we_c    = (cmd_q.idx != '0);
            wdata_c = s0_q;
         end
         default: ;
      endcase
   end

   // Architectural TOP/tag updates land at the end of the done cycle.
   always_comb begin
      top_nxt_c = bus.top;
      tag_nxt_c = bus.tag_word;
      if (state == ST_EXEC) begin
         case (cmd_q.op)
            OP_INIT: begin
               top_nxt_c = '0;
               tag_nxt_c = '1;
            end
            OP_PUSH: begin
               top_nxt_c = phys_q;
               tag_nxt_c = tag_set(bus.tag_word, phys_q, fault_q ? TAG_SPECIAL : cmd_q.tag);
            end
            OP_POP: begin
               top_nxt_c = bus.top + IDX_W'(1);
               tag_nxt_c = tag_set(bus.tag_word, bus.top, TAG_EMPTY);
            end
            OP_WRITE: tag_nxt_c = tag_set(bus.tag_word, phys_q, cmd_q.tag);
            OP_WRITE_POP: begin
               top_nxt_c = bus.top + IDX_W'(1);
               tag_nxt_c = tag_set(tag_set(bus.tag_word, phys_q, cmd_q.tag), bus.top, TAG_EMPTY);
            end
            OP_FREE:   tag_nxt_c = tag_set(bus.tag_word, phys_q, TAG_EMPTY);
            OP_INCSTP: top_nxt_c = bus.top + IDX_W'(1);
            OP_DECSTP: top_nxt_c = bus.top - IDX_W'(1);
            default: ;
         endcase
      end else if ((state == ST_XCH_WR2) && (cmd_q.idx != '0)) begin
         tag_nxt_c = tag_set(tag_set(bus.tag_word, bus.top, si_tag_q), phys_q, s0_tag_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state           <= ST_IDLE;
         bus.cmd_ready   <= 1'b1;
         bus.done        <= 1'b0;
         bus.exc_invalid <= 1'b0;
         bus.exc_sf      <= 1'b0;
         bus.c1          <= 1'b0;
         bus.rd_data     <= '0;
         bus.top         <= '0;
         bus.tag_word    <= '1;
         cmd_q           <= '0;
         phys_q          <= '0;
         data_q          <= '0;
         s0_q            <= '0;
         si_q            <= '0;
         s0_tag_q        <= TAG_EMPTY;
         si_tag_q        <= TAG_EMPTY;
         fault_q         <= 1'b0;
      end else begin
         bus.top         <= top_nxt_c;
         bus.tag_word    <= tag_nxt_c;
         bus.done        <= 1'b0;
         bus.exc_invalid <= 1'b0;
         bus.exc_sf      <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.cmd_valid && bus.cmd_ready) begin
                  state         <= ST_EXEC;
                  bus.cmd_ready <= 1'b0;
                  cmd_q         <= '{op: op_c, idx: bus.cmd_idx, tag: tag_e'(bus.cmd_tag)};
                  phys_q        <= (op_c == OP_PUSH) ? push_c : phys_i_c;
                  data_q        <= bus.cmd_data;
                  fault_q       <= fault_c;
                  s0_q          <= empty_s0_c ? INDEF : rd_s0_c;
                  s0_tag_q      <= empty_s0_c ? TAG_SPECIAL : tag_of(bus.tag_word, bus.top);
                  si_q          <= empty_i_c ? INDEF : rd_i_c;
                  si_tag_q      <= empty_i_c ? TAG_SPECIAL : tag_of(bus.tag_word, phys_i_c);
                  if (op_c != OP_XCH) begin
                     bus.done        <= 1'b1;
                     bus.exc_invalid <= fault_c;
                     bus.exc_sf      <= fault_c;
                     if (fault_c) begin
                        bus.c1 <= over_c;
                     end
                  end
                  if (op_c == OP_READ) begin
                     bus.rd_data <= empty_i_c ? INDEF : rd_i_c;
                  end
               end
            end
            ST_EXEC: begin
               if (cmd_q.op == OP_XCH) begin
                  state           <= ST_XCH_WR2;
                  bus.done        <= 1'b1;
                  bus.exc_invalid <= fault_q;
                  bus.exc_sf      <= fault_q;
                  if (fault_q) begin
                     bus.c1 <= 1'b0;
                  end
               end else begin
                  state         <= ST_IDLE;
                  bus.cmd_ready <= 1'b1;
                  if (cmd_q.op == OP_INIT) begin
                     bus.c1 <= 1'b0;
                  end
               end
            end
            ST_XCH_WR2: begin
               state         <= ST_IDLE;
               bus.cmd_ready <= 1'b1;
            end
            default: begin
               state         <= ST_IDLE;
               bus.cmd_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_stack_ctrl.sv
// Bench for fpu_stack_ctrl: array-based stack model checked on every cycle,
// plus literal expectations at key points of the directed sequence.
module tb_fpu_stack_ctrl;
   import fpu_stack_pkg::*;

   localparam logic [79:0] INDEF_V = 80'hFFFF_C000_0000_0000_0000;
   localparam logic [79:0] VAL_A   = 80'h3FFF_8000_0000_0000_0000;
   localparam logic [79:0] VAL_B   = 80'h4000_C000_0000_0000_0000;
   localparam logic [79:0] VAL_X   = 80'h4001_A000_0000_0000_0000;
   localparam logic [79:0] VAL_Y   = 80'h4002_9000_0000_0000_0000;
   localparam logic [79:0] VAL_Z   = 80'h4003_F000_0000_0000_1234;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   fpu_stack_ctrl_if #(.WIDTH(80)) bus ();

   fpu_stack_ctrl dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Behavioural stack model
   logic [79:0] m_reg [8];
   logic [1:0]  m_tag [8];
   logic [2:0]  m_top;
   logic        m_c1;
   logic        exp_done, exp_exc, exp_ready;
   logic [79:0] exp_rd;
   bit          mon_en = 1'b0;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic logic [15:0] tw_of();
      logic [15:0] r;
      for (int k = 0; k < 8; k++) r[2*k +: 2] = m_tag[k];
      return r;
   endfunction

   task automatic rst_model();
      m_top = 3'd0;
      for (int k = 0; k < 8; k++) m_tag[k] = 2'b11;
      m_c1      = 1'b0;
      exp_rd    = '0;
      exp_done  = 1'b0;
      exp_exc   = 1'b0;
      exp_ready = 1'b1;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk("done",        80'(bus.done),        80'(exp_done));
         chk("exc_invalid", 80'(bus.exc_invalid), 80'(exp_exc));
         chk("exc_sf",      80'(bus.exc_sf),      80'(exp_exc));
         chk("cmd_ready",   80'(bus.cmd_ready),   80'(exp_ready));
         chk("top",         80'(bus.top),         80'(m_top));
         chk("tag_word",    80'(bus.tag_word),    80'(tw_of()));
         chk("rd_data",     bus.rd_data,          exp_rd);
         if (exp_ready || exp_exc) chk("c1", 80'(bus.c1), 80'(m_c1));
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      rst_model();
   endtask

   task automatic issue(input logic [3:0] op, input logic [2:0] idx, input logic [79:0] data,
                        input logic [1:0] tg, input bit keep);
      int          n;
      bit          fault, over, is_xch;
      logic [2:0]  t, p, ntop;
      logic [79:0] nreg [8];
      logic [1:0]  ntag [8];
      logic [79:0] va, vb;
      logic [1:0]  ta, tb2;
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_idx   = idx;
      bus.cmd_data  = data;
      bus.cmd_tag   = tg;
      n = 0;
      while (bus.cmd_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         chk("accept_timeout", 80'd0, 80'd1);
         bus.cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      if (!keep) bus.cmd_valid = 1'b0;
      t = m_top;
      p = t + idx;
      nreg = m_reg;
      ntag = m_tag;
      ntop = t;
      fault = 1'b0;
      over = 1'b0;
      is_xch = (op == 4'd6);
      case (op)
         4'd1: begin
            for (int k = 0; k < 8; k++) ntag[k] = 2'b11;
            ntop = 3'd0;
         end
         4'd2: begin
            p = t - 3'd1;
            if (m_tag[p] == 2'b11) begin
               nreg[p] = data;
               ntag[p] = tg;
            end else begin
               fault = 1'b1;
               over = 1'b1;
               nreg[p] = INDEF_V;
               ntag[p] = 2'b10;
            end
            ntop = p;
         end
         4'd3: begin
            fault = (m_tag[t] == 2'b11);
            ntag[t] = 2'b11;
            ntop = t + 3'd1;
         end
         4'd4: begin
            fault = (m_tag[p] == 2'b11);
            exp_rd = fault ? INDEF_V : m_reg[p];
         end
         4'd5: begin
            nreg[p] = data;
            ntag[p] = tg;
         end
         4'd6: begin
            if (idx != 3'd0) begin
               va  = (m_tag[t] == 2'b11) ? INDEF_V : m_reg[t];
               ta  = (m_tag[t] == 2'b11) ? 2'b10 : m_tag[t];
               vb  = (m_tag[p] == 2'b11) ? INDEF_V : m_reg[p];
               tb2 = (m_tag[p] == 2'b11) ? 2'b10 : m_tag[p];
               fault = (m_tag[t] == 2'b11) || (m_tag[p] == 2'b11);
               nreg[t] = vb;
               ntag[t] = tb2;
               nreg[p] = va;
               ntag[p] = ta;
            end
         end
         4'd7: ntag[p] = 2'b11;
         4'd8: ntop = t + 3'd1;
         4'd9: ntop = t - 3'd1;
         4'd10: begin
            fault = (m_tag[t] == 2'b11);
            nreg[p] = data;
            ntag[p] = tg;
            ntag[t] = 2'b11;
            ntop = t + 3'd1;
         end
         default: ;
      endcase
      exp_ready = 1'b0;
      exp_done  = !is_xch;
      exp_exc   = fault && !is_xch;
      if (fault && !is_xch) m_c1 = over;
      @(posedge clk);
      #1;
      if (is_xch) begin
         exp_done = 1'b1;
         exp_exc  = fault;
         if (fault) m_c1 = 1'b0;
         @(posedge clk);
         #1;
      end
      exp_done  = 1'b0;
      exp_exc   = 1'b0;
      exp_ready = 1'b1;
      m_reg = nreg;
      m_tag = ntag;
      m_top = ntop;
      if (op == 4'd1) m_c1 = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = '0;
      bus.cmd_idx   = '0;
      bus.cmd_data  = '0;
      bus.cmd_tag   = '0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      rst_model();
      mon_en = 1'b1;
      chk("rst_top", 80'(bus.top), 80'd0);
      chk("rst_tag", 80'(bus.tag_word), 80'hFFFF);
      chk("rst_rd", bus.rd_data, 80'd0);
      chk("rst_done", 80'(bus.done), 80'd0);
      chk("rst_c1", 80'(bus.c1), 80'd0);

      // Single push then read back
      issue(4'd2, 3'd0, VAL_A, 2'b00, 1'b0);
      chk("push1_top", 80'(bus.top), 80'd7);
      chk("push1_tag", 80'(bus.tag_word), 80'h3FFF);
      issue(4'd4, 3'd0, '0, 2'b00, 1'b0);
      chk("push1_read", bus.rd_data, VAL_A);

      // Nine pushes: the ninth overflows into reg 7
      do_reset();
      for (int k = 0; k < 9; k++) issue(4'd2, 3'd0, VAL_B + 80'(k), 2'b00, 1'b0);
      chk("ovf_top", 80'(bus.top), 80'd7);
      chk("ovf_tag", 80'(bus.tag_word), 80'h8000);
      chk("ovf_c1", 80'(bus.c1), 80'd1);
      issue(4'd4, 3'd0, '0, 2'b00, 1'b0);
      chk("ovf_read", bus.rd_data, INDEF_V);
      issue(4'd1, 3'd0, '0, 2'b00, 1'b0);
      chk("init_top", 80'(bus.top), 80'd0);
      chk("init_tag", 80'(bus.tag_word), 80'hFFFF);
      chk("init_c1", 80'(bus.c1), 80'd0);

      // Underflow on empty stack
      do_reset();
      issue(4'd3, 3'd0, '0, 2'b00, 1'b0);
      chk("unf_top", 80'(bus.top), 80'd1);
      chk("unf_tag", 80'(bus.tag_word), 80'hFFFF);
      chk("unf_c1", 80'(bus.c1), 80'd0);
      issue(4'd4, 3'd3, '0, 2'b00, 1'b0);
      chk("unf_read", bus.rd_data, INDEF_V);

      // Exchange, with cmd_valid left high through the busy cycles
      do_reset();
      issue(4'd2, 3'd0, VAL_A, 2'b00, 1'b0);
      issue(4'd2, 3'd0, VAL_B, 2'b00, 1'b0);
      issue(4'd6, 3'd1, '0, 2'b00, 1'b1);
      issue(4'd4, 3'd0, '0, 2'b00, 1'b0);
      chk("xch_st0", bus.rd_data, VAL_A);
      issue(4'd4, 3'd1, '0, 2'b00, 1'b0);
      chk("xch_st1", bus.rd_data, VAL_B);
      issue(4'd6, 3'd0, '0, 2'b00, 1'b0);
      issue(4'd6, 3'd3, '0, 2'b00, 1'b0);
      issue(4'd4, 3'd3, '0, 2'b00, 1'b0);
      chk("xch_empty_st3", bus.rd_data, VAL_A);
      issue(4'd4, 3'd0, '0, 2'b00, 1'b0);
      chk("xch_empty_st0", bus.rd_data, INDEF_V);

      // TOP wrap
      do_reset();
      issue(4'd9, 3'd0, '0, 2'b00, 1'b0);
      chk("decstp_top", 80'(bus.top), 80'd7);
      issue(4'd8, 3'd0, '0, 2'b00, 1'b0);
      chk("incstp_top", 80'(bus.top), 80'd0);

      // WRITE_POP, WRITE, FREE, NOP and an undefined opcode
      do_reset();
      issue(4'd2, 3'd0, VAL_X, 2'b01, 1'b0);
      issue(4'd2, 3'd0, VAL_Y, 2'b00, 1'b0);
      issue(4'd10, 3'd1, VAL_Z, 2'b10, 1'b0);
      chk("wpop_top", 80'(bus.top), 80'd7);
      chk("wpop_tag", 80'(bus.tag_word), 80'hBFFF);
      issue(4'd4, 3'd0, '0, 2'b00, 1'b0);
      chk("wpop_read", bus.rd_data, VAL_Z);
      issue(4'd5, 3'd2, VAL_X, 2'b01, 1'b0);
      issue(4'd10, 3'd0, VAL_Y, 2'b00, 1'b0);
      issue(4'd7, 3'd1, '0, 2'b00, 1'b0);
      issue(4'd0, 3'd0, '0, 2'b00, 1'b0);
      issue(4'd15, 3'd5, VAL_A, 2'b00, 1'b0);
      issue(4'd4, 3'd1, '0, 2'b00, 1'b0);

      // Reset landing in the second XCH cycle
      do_reset();
      issue(4'd2, 3'd0, VAL_A, 2'b00, 1'b0);
      issue(4'd2, 3'd0, VAL_B, 2'b00, 1'b0);
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 4'd6;
      bus.cmd_idx   = 3'd1;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      exp_ready = 1'b0;
      exp_done  = 1'b0;
      exp_exc   = 1'b0;
      @(posedge clk);
      #1;
      exp_done = 1'b1;
      reset_n  = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      rst_model();
      chk("midxch_top", 80'(bus.top), 80'd0);
      chk("midxch_tag", 80'(bus.tag_word), 80'hFFFF);
      chk("midxch_done", 80'(bus.done), 80'd0);
      chk("midxch_ready", 80'(bus.cmd_ready), 80'd1);
      issue(4'd2, 3'd0, VAL_Z, 2'b00, 1'b0);
      issue(4'd4, 3'd0, '0, 2'b00, 1'b0);
      chk("post_rst_read", bus.rd_data, VAL_Z);

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
